// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the CPU access path and a
//               debug/loader master. Serialises accesses, holds each for
//               MEM_LAT cycles and returns read data with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int MEM_LAT  = 2,   // cycles the port is held per access (1..15)
    parameter int ARB_MODE = 0    // 0 = round-robin, 1 = CPU wins ties
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic [1:0]  cpu_wr,
    input  logic [2:0]  cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic [1:0]  dbg_wr,
    input  logic [2:0]  dbg_re,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_done,
    output logic [31:0] dbg_rdata,

    output logic        mem_en,
    output logic [1:0]  mem_wr,
    output logic [2:0]  mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    localparam logic       c_own_cpu   = 1'b0;
    localparam logic       c_own_dbg   = 1'b1;

    localparam logic [3:0] c_lat_m1    = 4'(MEM_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_last_owner;
    logic [1:0]  r_wr;
    logic [2:0]  r_re;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dbg_rdata;

    logic        w_grant;
    logic        w_grant_owner;
    logic        w_tie_to_dbg;
    logic        w_in_access;

    // Round-robin hands a tie to DBG only when the CPU had the port last.
    assign w_tie_to_dbg = (ARB_MODE == 0) && (r_last_owner == c_own_cpu);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = c_own_cpu;
        case (r_state)
            c_st_idle: begin
                if (cpu_req || dbg_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_st_access;
                    if (dbg_req && (!cpu_req || w_tie_to_dbg)) begin
                        w_grant_owner = c_own_dbg;
                    end
                end
            end
            c_st_access: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 4'd0;
            r_owner      <= c_own_cpu;
            r_last_owner <= c_own_dbg;
            r_wr         <= 2'd0;
            r_re         <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_cpu_rdata  <= 32'd0;
            r_dbg_rdata  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_owner <= w_grant_owner;
                        r_cnt   <= c_lat_m1;
                        if (w_grant_owner == c_own_dbg) begin
                            r_wr    <= dbg_wr;
                            r_re    <= dbg_re;
                            r_addr  <= dbg_addr;
                            r_wdata <= dbg_wdata;
                        end else begin
                            r_wr    <= cpu_wr;
                            r_re    <= cpu_re;
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                        end
                    end
                end
                c_st_access: begin
                    if (r_cnt == 4'd0) begin
                        if (r_owner == c_own_dbg) begin
                            r_dbg_rdata <= mem_rdata;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_done: begin
                    r_last_owner <= r_owner;
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign w_in_access = (r_state == c_st_access);

    // The counter still holds its load value only in the first ACCESS cycle,
    // so the write strobe is presented exactly once per access.
    assign mem_en    = w_in_access;
    assign mem_wr    = (w_in_access && (r_cnt == c_lat_m1)) ? r_wr : 2'd0;
    assign mem_re    = w_in_access ? r_re    : 3'd0;
    assign mem_addr  = w_in_access ? r_addr  : 32'd0;
    assign mem_wdata = w_in_access ? r_wdata : 32'd0;

    assign cpu_done  = (r_state == c_st_done) && (r_owner == c_own_cpu);
    assign dbg_done  = (r_state == c_st_done) && (r_owner == c_own_dbg);
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;

    assign busy      = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven bench for mem_port_arbiter with a
//               round-robin instance and a fixed-priority instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [1:0]  cpu_wr;
    logic [2:0]  cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dbg_req;
    logic [1:0]  dbg_wr;
    logic [2:0]  dbg_re;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;

    logic        cpu_done_rr, dbg_done_rr, mem_en_rr, busy_rr;
    logic [31:0] cpu_rdata_rr, dbg_rdata_rr, mem_addr_rr, mem_wdata_rr, mem_rdata_rr;
    logic [1:0]  mem_wr_rr;
    logic [2:0]  mem_re_rr;

    logic        cpu_done_fp, dbg_done_fp, mem_en_fp, busy_fp;
    logic [31:0] cpu_rdata_fp, dbg_rdata_fp, mem_addr_fp, mem_wdata_fp, mem_rdata_fp;
    logic [1:0]  mem_wr_fp;
    logic [2:0]  mem_re_fp;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ARB_MODE(0)) u_dut_rr (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_done(cpu_done_rr), .cpu_rdata(cpu_rdata_rr),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_re(dbg_re), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_done(dbg_done_rr), .dbg_rdata(dbg_rdata_rr),
        .mem_en(mem_en_rr), .mem_wr(mem_wr_rr), .mem_re(mem_re_rr), .mem_addr(mem_addr_rr),
        .mem_wdata(mem_wdata_rr), .mem_rdata(mem_rdata_rr), .busy(busy_rr)
    );

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ARB_MODE(1)) u_dut_fp (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_done(cpu_done_fp), .cpu_rdata(cpu_rdata_fp),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_re(dbg_re), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_done(dbg_done_fp), .dbg_rdata(dbg_rdata_fp),
        .mem_en(mem_en_fp), .mem_wr(mem_wr_fp), .mem_re(mem_re_fp), .mem_addr(mem_addr_fp),
        .mem_wdata(mem_wdata_fp), .mem_rdata(mem_rdata_fp), .busy(busy_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small word memory behind the round-robin instance.
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
    end
    always @(posedge clk) begin
        if (mem_en_rr && (mem_wr_rr != 2'd0)) mem[mem_addr_rr[5:2]] <= mem_wdata_rr;
    end
    assign mem_rdata_rr = mem_en_rr ? mem[mem_addr_rr[5:2]] : 32'd0;
    assign mem_rdata_fp = mem_en_fp ? (mem_addr_fp ^ {mem_wdata_fp[15:0], 16'h5A5A}
                                       ^ {27'd0, mem_re_fp, mem_wr_fp}) : 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_dbg;
        logic [1:0]  wr;
        logic [2:0]  re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cyc, en_cyc, wr_cyc, other_done, addr_bad, n_rr, n_fp, pulse_err, ndone;
        logic [31:0] wd_seen;
        logic [1:0]  wr_seen;
        logic        own_done, oth_done, got, first_cpu, first_dbg;
        logic        p_c_rr, p_d_rr, p_c_fp, p_d_fp;
        logic [3:0]  ord_rr;
        logic [4:0]  ord_fp;

        vecs[0] = '{1'b0, 2'd0, 3'd1, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 2'd1, 3'd0, 32'h20, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b0, 2'd0, 3'd1, 32'h20, 32'h0,        32'h12345678};
        vecs[3] = '{1'b1, 2'd0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b0, 2'd2, 3'd0, 32'h14, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 2'd0, 3'd4, 32'h14, 32'h0,        32'hCAFEF00D};

        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 2'd0; cpu_re = 3'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dbg_req = 1'b0; dbg_wr = 2'd0; dbg_re = 3'd0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
        tick();
        tick();
        chk("reset busy",      {31'd0, busy_rr},     32'd0);
        chk("reset mem_en",    {31'd0, mem_en_rr},   32'd0);
        chk("reset mem_wr",    {30'd0, mem_wr_rr},   32'd0);
        chk("reset mem_addr",  mem_addr_rr,          32'd0);
        chk("reset cpu_done",  {31'd0, cpu_done_rr}, 32'd0);
        chk("reset dbg_done",  {31'd0, dbg_done_rr}, 32'd0);
        chk("reset cpu_rdata", cpu_rdata_rr,         32'd0);
        chk("reset dbg_rdata", dbg_rdata_rr,         32'd0);
        chk("reset busy fp",   {31'd0, busy_fp},     32'd0);
        rst = 1'b0;
        tick();

        // Single accesses, one requester at a time.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_dbg) begin
                dbg_wr = vecs[v].wr; dbg_re = vecs[v].re;
                dbg_addr = vecs[v].addr; dbg_wdata = vecs[v].wdata; dbg_req = 1'b1;
            end else begin
                cpu_wr = vecs[v].wr; cpu_re = vecs[v].re;
                cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata; cpu_req = 1'b1;
            end
            done_cyc = 0; en_cyc = 0; wr_cyc = 0; other_done = 0; addr_bad = 0;
            wd_seen = 32'd0; wr_seen = 2'd0;
            for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
                tick();
                if (mem_en_rr) begin
                    en_cyc++;
                    if (mem_addr_rr !== vecs[v].addr || mem_re_rr !== vecs[v].re) addr_bad++;
                end
                if (mem_wr_rr != 2'd0) begin
                    wr_cyc++; wd_seen = mem_wdata_rr; wr_seen = mem_wr_rr;
                end
                own_done = vecs[v].is_dbg ? dbg_done_rr : cpu_done_rr;
                oth_done = vecs[v].is_dbg ? cpu_done_rr : dbg_done_rr;
                if (oth_done) other_done++;
                if (own_done) done_cyc = k;
            end
            chk($sformatf("v%0d done latency", v), done_cyc, MEM_LAT + 1);
            chk($sformatf("v%0d mem_en cycles", v), en_cyc, MEM_LAT);
            chk($sformatf("v%0d addr/re held", v), addr_bad, 0);
            chk($sformatf("v%0d write cycles", v), wr_cyc, (vecs[v].wr != 2'd0) ? 1 : 0);
            if (vecs[v].wr != 2'd0) begin
                chk($sformatf("v%0d mem_wdata", v), wd_seen, vecs[v].wdata);
                chk($sformatf("v%0d mem_wr code", v), {30'd0, wr_seen}, {30'd0, vecs[v].wr});
            end
            chk($sformatf("v%0d rdata", v),
                vecs[v].is_dbg ? dbg_rdata_rr : cpu_rdata_rr, vecs[v].exp_rdata);
            chk($sformatf("v%0d other done", v), other_done, 0);
            cpu_req = 1'b0; dbg_req = 1'b0;
            tick();
            chk($sformatf("v%0d idle busy", v), {31'd0, busy_rr}, 32'd0);
            chk($sformatf("v%0d done width", v),
                {31'd0, vecs[v].is_dbg ? dbg_done_rr : cpu_done_rr}, 32'd0);
        end
        cpu_wr = 2'd0; dbg_wr = 2'd0;

        // Contention with both requests held continuously.
        cpu_re = 3'd1; cpu_addr = 32'h10; dbg_re = 3'd1; dbg_addr = 32'h14;
        cpu_req = 1'b1; dbg_req = 1'b1;
        n_rr = 0; n_fp = 0; pulse_err = 0; ord_rr = 4'd0; ord_fp = 5'd0;
        p_c_rr = 1'b0; p_d_rr = 1'b0; p_c_fp = 1'b0; p_d_fp = 1'b0;
        for (int k = 0; k < 60 && n_rr < 4; k++) begin
            tick();
            if (cpu_done_rr && n_rr < 4) begin ord_rr[n_rr] = 1'b0; n_rr++; end
            if (dbg_done_rr && n_rr < 4) begin ord_rr[n_rr] = 1'b1; n_rr++; end
            if (cpu_done_fp && n_fp < 5) begin ord_fp[n_fp] = 1'b0; n_fp++; end
            if (dbg_done_fp && n_fp < 5) begin ord_fp[n_fp] = 1'b1; n_fp++; end
            if ((cpu_done_rr && p_c_rr) || (dbg_done_rr && p_d_rr) ||
                (cpu_done_fp && p_c_fp) || (dbg_done_fp && p_d_fp)) pulse_err++;
            p_c_rr = cpu_done_rr; p_d_rr = dbg_done_rr;
            p_c_fp = cpu_done_fp; p_d_fp = dbg_done_fp;
        end
        cpu_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (cpu_done_fp && n_fp < 5) begin ord_fp[n_fp] = 1'b0; n_fp++; end
            if (dbg_done_fp && n_fp < 5) begin ord_fp[n_fp] = 1'b1; n_fp++; got = 1'b1; end
        end
        dbg_req = 1'b0;
        tick();
        tick();
        chk("rr grant count", n_rr, 4);
        chk("rr grant order", {28'd0, ord_rr}, 32'h0000000A);
        chk("fp grant count", n_fp, 5);
        chk("fp grant order", {27'd0, ord_fp}, 32'h00000010);
        chk("contention pulse width", pulse_err, 0);
        chk("rr cpu rdata", cpu_rdata_rr, 32'hDEADBEEF);
        chk("rr dbg rdata", dbg_rdata_rr, 32'hCAFEF00D);
        chk("contention idle", {31'd0, busy_rr}, 32'd0);

        // Address change after the latch edge is ignored.
        cpu_re = 3'd1; cpu_addr = 32'h10; cpu_req = 1'b1;
        tick();
        chk("latch addr c1", mem_addr_rr, 32'h10);
        cpu_addr = 32'h40;
        tick();
        chk("latch addr c2", mem_addr_rr, 32'h10);
        chk("latch en c2", {31'd0, mem_en_rr}, 32'd1);
        tick();
        chk("latch done", {31'd0, cpu_done_rr}, 32'd1);
        chk("latch rdata", cpu_rdata_rr, 32'hDEADBEEF);
        cpu_req = 1'b0;
        tick();

        // Reset in the second ACCESS cycle of a CPU write.
        cpu_wr = 2'd1; cpu_re = 3'd0; cpu_addr = 32'h18; cpu_wdata = 32'h11111111;
        cpu_req = 1'b1;
        tick();
        chk("rst-mid first wr", {30'd0, mem_wr_rr}, 32'd1);
        tick();
        chk("rst-mid second en", {31'd0, mem_en_rr}, 32'd1);
        chk("rst-mid second wr", {30'd0, mem_wr_rr}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rst-mid mem_en", {31'd0, mem_en_rr}, 32'd0);
        chk("rst-mid busy", {31'd0, busy_rr}, 32'd0);
        chk("rst-mid cpu_rdata", cpu_rdata_rr, 32'd0);
        ndone = cpu_done_rr ? 1 : 0;
        rst = 1'b0; cpu_req = 1'b0; cpu_wr = 2'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cpu_done_rr) ndone++;
        end
        chk("rst-mid no done", ndone, 0);

        cpu_re = 3'd1; cpu_addr = 32'h10; dbg_re = 3'd1; dbg_addr = 32'h20;
        cpu_req = 1'b1; dbg_req = 1'b1;
        first_cpu = 1'b0; first_dbg = 1'b0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (cpu_done_rr || dbg_done_rr) begin
                got = 1'b1; first_cpu = cpu_done_rr; first_dbg = dbg_done_rr;
            end
        end
        chk("post-rst tie cpu", {31'd0, first_cpu}, 32'd1);
        chk("post-rst tie dbg", {31'd0, first_dbg}, 32'd0);
        chk("post-rst cpu rdata", cpu_rdata_rr, 32'hDEADBEEF);
        cpu_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (dbg_done_rr) got = 1'b1;
        end
        chk("post-rst dbg served", {31'd0, got}, 32'd1);
        chk("post-rst dbg rdata", dbg_rdata_rr, 32'h12345678);
        dbg_req = 1'b0;
        tick();
        tick();
        chk("final idle", {31'd0, busy_rr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters:
  - the CPU access path (instruction fetch and data, address already selected by the IorD mux);
  - a debug/loader master (program preload, memory inspection).
- Sits between requesters and the memory block.
- Serialises accesses, holds each for a fixed memory latency, returns read data with a one-cycle done pulse.
- Arbitration is round-robin or fixed CPU priority, selected by parameter.

Parameters:
- MEM_LAT, 2: cycles the memory port is held per access (1..15).
- ARB_MODE, 0: 0 = round-robin, 1 = CPU always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_wr  in  2  write-size code (DMWr encoding; 0 = no write).
- cpu_re  in  3  read-size code (DMRe encoding).
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid when cpu_done=1.
- dbg_req  in  1  debug request; held until dbg_done.
- dbg_wr  in  2  write-size code.
- dbg_re  in  3  read-size code.
- dbg_addr  in  32  debug address.
- dbg_wdata  in  32  debug write data.
- dbg_done  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  read data, valid when dbg_done=1.
- mem_en  out  1  memory port active (drives memory "work").
- mem_wr  out  2  write-size code to memory.
- mem_re  out  3  read-size code to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, cnt=0, last_owner=DBG (so the CPU wins the first tie).
  - All outputs 0, including the rdata registers.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: ARB_MODE=1 grants CPU. ARB_MODE=0 grants the requester that is not last_owner.
  - On grant, at the next edge: latch owner, wr, re, addr, wdata; cnt=MEM_LAT-1; state=ACCESS.
- ACCESS:
  - mem_en=1; mem_addr, mem_re, mem_wdata driven from the latched values.
  - mem_wr equals the latched wr only in the first ACCESS cycle, 0 afterwards (no repeated writes).
  - cnt decrements each cycle.
  - At cnt==0: capture mem_rdata into the owner's rdata register; state=DONE.
- DONE:
  - Owner's done=1 for exactly this cycle; last_owner=owner.
  - Next state is IDLE unconditionally.
  - mem_en=0 and all mem_* outputs are 0 outside ACCESS.
- Latency: req high at the edge entering cycle 0 gives done high in cycle MEM_LAT+1. One IDLE cycle separates consecutive accesses.
- Handshake:
  - Requester holds req, wr, re, addr, wdata stable from assertion until it samples done.
  - Requester may deassert req in the cycle after done.
  - If req is still high in IDLE, it is a new request.
  - Changes to inputs after the latch edge are ignored.
- The non-owner's done stays 0 and its rdata holds its previous value.
- A request arriving during ACCESS/DONE waits. It is never dropped; it is served at the next IDLE.
- Round-robin gives no starvation: with both requesting continuously, grants alternate.
- Reset mid-access: at the next edge go to IDLE with mem_en=0 and no done pulse. A partially started write is not retried.
- busy=1 in ACCESS and DONE.

Test Plan:
- Single CPU read:
  - Stimulus: MEM_LAT=2, cpu_req=1 with addr=0x10, re=word; memory returns 0xDEADBEEF.
  - Response: mem_en high for 2 cycles, cpu_done in cycle 3, cpu_rdata=0xDEADBEEF, dbg_done never high.
- Debug write:
  - Stimulus: dbg_wr=word, addr=0x20, wdata=0x12345678.
  - Response: mem_wr nonzero only in the first ACCESS cycle, mem_wdata=0x12345678, dbg_done pulses once.
- Contention, ARB_MODE=0:
  - Stimulus: both requesters hold req continuously for 4 accesses.
  - Response: grant order CPU, DBG, CPU, DBG; each done a single-cycle pulse.
- Contention, ARB_MODE=1:
  - Stimulus: both hold req; CPU re-requests immediately after each done.
  - Response: CPU served every time; DBG served only once CPU drops req.
- Reset mid-access:
  - Stimulus: rst in the second ACCESS cycle of a CPU write.
  - Response: next cycle IDLE, mem_en=0, no cpu_done, busy=0. A later request completes normally with CPU winning the tie.
- Input change after latch:
  - Stimulus: cpu_addr changes 0x10→0x40 during ACCESS.
  - Response: mem_addr stays 0x10 for the whole access.
